// File: rtl/instruction_fetch.sv
// Instruction fetch stage feeding control_unit: writable program memory, program
// counter and instruction register. The presented word stays stable while the
// control unit works through an instruction; the stage advances on run && done1.
// Optional feature: define IFETCH_HALT_EN to make 16'hFFFF a halt word.
module instruction_fetch #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              done1,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [15:0]       retired
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    // J-type NOP: presented out of reset and while halted
    localparam logic [DATA_W-1:0] NopWord = DATA_W'(16'h0002);
`ifdef IFETCH_HALT_EN
    localparam logic [DATA_W-1:0] HaltWord = '1;
`endif

`ifdef IFETCH_HALT_EN
    typedef enum logic [1:0] {StFetch, StHold, StIdle, StHalt} state_e;
`else
    typedef enum logic [1:0] {StFetch, StHold, StIdle} state_e;
`endif

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         retired_q, retired_d;
    logic [DATA_W-1:0]   mem_q [Depth];
    logic [DATA_W-1:0]   rd_word;
    logic                adv;
    logic                frozen;

    assign rd_word = mem_q[pc_q];
    assign adv     = run && done1;

`ifdef IFETCH_HALT_EN
    assign frozen = (state_q == StHalt);
`else
    assign frozen = 1'b0;
`endif

    // Program memory: not reset, writable only while the core is stopped
    always_ff @(posedge clk) begin
        if (prog_we && !run) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // State register plus PC, instruction register and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            instr_q   <= NopWord;
            pc_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                state_d = StHold;
`ifdef IFETCH_HALT_EN
                if (rd_word == HaltWord) begin
                    state_d = StHalt;
                end
`endif
            end
            StHold: begin
                if (adv) begin
                    state_d = StFetch;
                end else if (!run) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (adv) begin
                    state_d = StFetch;
                end else if (run) begin
                    state_d = StHold;
                end
            end
`ifdef IFETCH_HALT_EN
            StHalt: state_d = StHalt;
`endif
            default: state_d = StFetch;
        endcase
    end

    // Datapath updates: instruction reload per state, PC/retire step on advance
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        case (state_q)
            StFetch: begin
                instr_d = rd_word;
`ifdef IFETCH_HALT_EN
                // A halt word is never presented to the control unit
                if (rd_word == HaltWord) begin
                    instr_d = NopWord;
                end
`endif
            end
            StIdle: instr_d = rd_word;
`ifdef IFETCH_HALT_EN
            StHalt: instr_d = NopWord;
`endif
            default: instr_d = instr_q;
        endcase
        if (adv && !frozen) begin
            pc_d      = jump_en ? jump_target : pc_q + 1'b1;
            retired_d = retired_q + 16'd1;
        end
    end

    assign instruction = instr_q;
    assign pc          = pc_q;
    assign retired     = retired_q;
    assign halted      = frozen;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, hand-written
// corner sequences (wrap, reset mid-hold, halt) and randomized instruction/program
// traffic against a memory-array reference model.
module tb_instruction_fetch;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          run, done1, jump_en, prog_we;
    logic [AW-1:0] jump_target, prog_addr;
    logic [15:0]   prog_data;
    logic [15:0]   instruction;
    logic [AW-1:0] pc;
    logic          halted;
    logic [15:0]   retired;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0]   mem_m [16];
    int unsigned   pc_m;
    int unsigned   ret_m;

    instruction_fetch #(.ADDR_W(AW), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .done1       (done1),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instruction (instruction),
        .pc          (pc),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        done1;
        logic        jump_en;
        logic [3:0]  jt;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [3:0]  exp_pc;
        logic        chk_instr;
        logic [15:0] exp_instr;
        logic [15:0] exp_ret;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        run = 1'b0; done1 = 1'b0; jump_en = 1'b0; jump_target = '0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    endtask

    task automatic add(input logic r, input logic d, input logic j, input logic [3:0] jt,
                       input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [3:0] epc, input logic ci, input logic [15:0] ei,
                       input logic [15:0] er);
        vec_t v;
        v.run = r; v.done1 = d; v.jump_en = j; v.jt = jt; v.we = we; v.wa = wa; v.wd = wd;
        v.exp_pc = epc; v.chk_instr = ci; v.exp_instr = ei; v.exp_ret = er;
        vecs.push_back(v);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_instr"}, 32'(instruction), 32'h0002);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_retired"}, 32'(retired), 32'd0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1 check_reset_values("reset_pulse");
        #1 reset = 1'b0;
    endtask

    // Random program op: one write with run low, then an idle reload
    task automatic rand_program();
        logic [3:0]  a;
        logic [15:0] d;
        a = 4'($urandom_range(0, 15));
        d = 16'($urandom_range(0, 16'hFFFE));
        idle_inputs();
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        mem_m[a] = d;
        idle_inputs();
        tick();
        check("rand_prog_instr", 32'(instruction), 32'(mem_m[pc_m]));
        check("rand_prog_pc", 32'(pc), 32'(pc_m));
    endtask

    // Random instruction op: run cycles with noise, a done1 strobe, then the reload
    task automatic rand_instr();
        int          waits;
        logic        j;
        logic [3:0]  t;
        waits = $urandom_range(1, 3);
        for (int w = 0; w < waits; w++) begin
            idle_inputs();
            run = 1'b1;
            jump_en = 1'($urandom_range(0, 1));
            jump_target = 4'($urandom_range(0, 15));
            prog_we = 1'($urandom_range(0, 1));
            prog_addr = pc_m[3:0];
            prog_data = 16'hDEAD;
            tick();
            check("rand_hold_instr", 32'(instruction), 32'(mem_m[pc_m]));
            check("rand_hold_pc", 32'(pc), 32'(pc_m));
        end
        j = 1'($urandom_range(0, 1));
        t = 4'($urandom_range(0, 15));
        idle_inputs();
        run = 1'b1; done1 = 1'b1; jump_en = j; jump_target = t;
        tick();
        pc_m  = j ? 32'(t) : (pc_m + 1) % 16;
        ret_m = (ret_m + 1) % 65536;
        check("rand_adv_pc", 32'(pc), 32'(pc_m));
        check("rand_adv_ret", 32'(retired), 32'(ret_m));
        idle_inputs();
        run = 1'b1;
        tick();
        check("rand_fetch_instr", 32'(instruction), 32'(mem_m[pc_m]));
        tick();
        check("rand_stable_instr", 32'(instruction), 32'(mem_m[pc_m]));
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // Directed vectors: programming in idle, hold, jumps, ignored writes
        add(0,0,0,0, 1,4'd0,16'h2401, 0, 0,16'h0000, 0);
        add(0,0,0,0, 1,4'd1,16'h4805, 0, 1,16'h2401, 0);
        add(0,0,0,0, 1,4'd2,16'h0000, 0, 1,16'h2401, 0);
        add(0,0,0,0, 1,4'd7,16'hA5A5, 0, 1,16'h2401, 0);
        add(0,0,0,0, 1,4'd0,16'h1234, 0, 1,16'h2401, 0);
        add(0,0,0,0, 0,4'd0,16'h0000, 0, 1,16'h1234, 0);
        add(0,0,0,0, 1,4'd0,16'h2401, 0, 1,16'h1234, 0);
        add(0,0,0,0, 0,4'd0,16'h0000, 0, 1,16'h2401, 0);
        add(1,0,0,0, 0,4'd0,16'h0000, 0, 1,16'h2401, 0);
        add(1,0,0,0, 1,4'd0,16'hBEEF, 0, 1,16'h2401, 0);
        add(1,0,1,7, 0,4'd0,16'h0000, 0, 1,16'h2401, 0);
        add(1,1,0,0, 0,4'd0,16'h0000, 1, 1,16'h2401, 1);
        add(1,0,0,0, 0,4'd0,16'h0000, 1, 1,16'h4805, 1);
        add(1,0,0,0, 0,4'd0,16'h0000, 1, 1,16'h4805, 1);
        add(1,1,0,0, 0,4'd0,16'h0000, 2, 1,16'h4805, 2);
        add(1,0,0,0, 0,4'd0,16'h0000, 2, 1,16'h0000, 2);
        add(1,1,1,7, 0,4'd0,16'h0000, 7, 1,16'h0000, 3);
        add(1,0,0,0, 0,4'd0,16'h0000, 7, 1,16'hA5A5, 3);
        add(0,0,0,0, 0,4'd0,16'h0000, 7, 1,16'hA5A5, 3);
        add(0,0,0,0, 0,4'd0,16'h0000, 7, 1,16'hA5A5, 3);

        #3;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();

        foreach (vecs[i]) begin
            run = vecs[i].run; done1 = vecs[i].done1; jump_en = vecs[i].jump_en;
            jump_target = vecs[i].jt; prog_we = vecs[i].we;
            prog_addr = vecs[i].wa; prog_data = vecs[i].wd;
            tick();
            check($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            check($sformatf("vec%0d_ret", i), 32'(retired), 32'(vecs[i].exp_ret));
            if (vecs[i].chk_instr) begin
                check($sformatf("vec%0d_instr", i), 32'(instruction), 32'(vecs[i].exp_instr));
            end
        end

        // PC wrap from the last address
        idle_inputs(); prog_we = 1'b1; prog_addr = 4'd15; prog_data = 16'h0F0F;
        tick();
        idle_inputs(); run = 1'b1;
        tick();
        done1 = 1'b1; jump_en = 1'b1; jump_target = 4'd15;
        tick();
        check("jump15_pc", 32'(pc), 32'd15);
        idle_inputs(); run = 1'b1;
        tick();
        check("jump15_instr", 32'(instruction), 32'h0F0F);
        done1 = 1'b1;
        tick();
        check("wrap_pc", 32'(pc), 32'd0);
        check("wrap_ret", 32'(retired), 32'd5);
        done1 = 1'b0;
        tick();
        check("wrap_instr", 32'(instruction), 32'h2401);

        // Reset mid-hold; memory survives, ignored run-high write left mem[0] intact
        tick();
        pulse_reset();
        tick();
        check("post_reset_instr", 32'(instruction), 32'h2401);
        check("post_reset_pc", 32'(pc), 32'd0);

        // Randomized traffic against the model
        idle_inputs();
        tick();
        for (int a = 0; a < 16; a++) begin
            mem_m[a] = 16'($urandom_range(0, 16'hFFFE));
            prog_we = 1'b1; prog_addr = 4'(a); prog_data = mem_m[a];
            tick();
        end
        idle_inputs();
        tick();
        pc_m = 0;
        ret_m = 0;
        check("rand_init_instr", 32'(instruction), 32'(mem_m[0]));
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) rand_program();
            else rand_instr();
        end

        // Halt word at address 1
        idle_inputs();
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'h1111;
        tick();
        prog_addr = 4'd1; prog_data = 16'hFFFF;
        tick();
        idle_inputs();
        pulse_reset();
        tick();
        tick();
        run = 1'b1;
        tick();
        check("halt_pre_instr", 32'(instruction), 32'h1111);
        done1 = 1'b1;
        tick();
        check("halt_adv_pc", 32'(pc), 32'd1);
        done1 = 1'b0;
        tick();
`ifdef IFETCH_HALT_EN
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_instr", 32'(instruction), 32'h0002);
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        tick();
        check("halt_frozen_pc", 32'(pc), 32'd1);
        check("halt_frozen_ret", 32'(retired), 32'd1);
        check("halt_still_instr", 32'(instruction), 32'h0002);
`else
        check("nohalt_halted", 32'(halted), 32'd0);
        check("nohalt_instr", 32'(instruction), 32'hFFFF);
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        check("nohalt_pc", 32'(pc), 32'd2);
        check("nohalt_ret", 32'(retired), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
